// File: rtl/arm_lp_pkg.sv
// Shared ARM-LP definitions: ALU opcodes, execute-stage FSM states, default datapath width.
package arm_lp_pkg;

    localparam int unsigned WIDTH_DEFAULT = 32;

    typedef enum logic [3:0] {
        OpAnd   = 4'b0000,
        OpOrr   = 4'b0001,
        OpAdd   = 4'b0010,
        OpSub   = 4'b0110,
        OpPassB = 4'b0111,
        OpNor   = 4'b1100,
        OpMul   = 4'b1000
    } alu_op_e;

    typedef enum logic [0:0] {
        StIdle,
        StMul
    } state_e;

    function automatic logic is_single_cycle_op(input logic [3:0] op);
        logic ok;
        case (op)
            OpAnd, OpOrr, OpAdd, OpSub, OpPassB, OpNor: ok = 1'b1;
            default:                                    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/execute_stage_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per clock, low WIDTH bits of the product.
module mul_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEPS = WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int unsigned CntW = $clog2(STEPS + 1);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] acc_step;
    logic             last_step;

    // done/product are combinational so the caller can register the result on the final step edge.
    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last_step = busy_q && (cnt_q == CntW'(STEPS - 1));

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start_i) begin
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            busy_d   = !last_step;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = last_step;
    assign product_o = acc_step;

endmodule

// File: rtl/execute_stage.sv
// ARM-LP execute stage: registered ALU result, flags and branch target.
// Optional iterative multiplier enabled by defining EXEC_MUL_EN.
module execute_stage
    import arm_lp_pkg::*;
#(
    parameter int unsigned WIDTH     = arm_lp_pkg::WIDTH_DEFAULT,
    parameter int unsigned MUL_STEPS = WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             validIn,
    input  logic [3:0]       aluOp,
    input  logic             aluSRC,
    input  logic [WIDTH-1:0] readData1,
    input  logic [WIDTH-1:0] readData2,
    input  logic [WIDTH-1:0] pcOffsetFilled,
    input  logic [WIDTH-1:0] pcIn,
    input  logic [4:0]       writeRegisterIn,
    input  logic             regWriteIn,
    output logic             stall,
    output logic             validOut,
    output logic [WIDTH-1:0] aluResult,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic [WIDTH-1:0] branchTarget,
    output logic [4:0]       writeRegisterOut,
    output logic             regWriteOut
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] btgt_q, btgt_d;
    logic [4:0]       wreg_q, wreg_d;
    logic             regw_q, regw_d;
    logic             valid_q, valid_d;

    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             add_ovf;
    logic             is_sub;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic [WIDTH-1:0] btgt_new;
    logic             accept_mul;
    logic             accept_alu;

    assign btgt_new = pcIn + (pcOffsetFilled << 2);

    // SUB reuses the adder as A + ~B + 1 so carry/overflow come from the same path.
    always_comb begin
        op_b   = aluSRC ? pcOffsetFilled : readData2;
        is_sub = (aluOp == OpSub);
        add_b  = is_sub ? ~op_b : op_b;
        {add_cout, add_sum} = {1'b0, readData1} + {1'b0, add_b} + {{WIDTH{1'b0}}, is_sub};
        add_ovf = (readData1[WIDTH-1] == add_b[WIDTH-1]) &&
                  (add_sum[WIDTH-1] != readData1[WIDTH-1]);
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (aluOp)
            OpAnd:   alu_res = readData1 & op_b;
            OpOrr:   alu_res = readData1 | op_b;
            OpAdd,
            OpSub: begin
                alu_res = add_sum;
                alu_c   = add_cout;
                alu_v   = add_ovf;
            end
            OpPassB: alu_res = op_b;
            OpNor:   alu_res = ~(readData1 | op_b);
            default: alu_res = '0;
        endcase
    end

`ifdef EXEC_MUL_EN
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;
    logic             stall_q, stall_d;
    logic [WIDTH-1:0] hold_btgt_q, hold_btgt_d;
    logic [4:0]       hold_wreg_q, hold_wreg_d;
    logic             hold_regw_q, hold_regw_d;

    assign accept_mul = (state_q == StIdle) && validIn && (aluOp == OpMul);

    mul_iter #(
        .WIDTH (WIDTH),
        .STEPS (MUL_STEPS)
    ) u_mul_iter (
        .clk_i     (clock),
        .rst_i     (reset),
        .start_i   (accept_mul),
        .a_i       (readData1),
        .b_i       (op_b),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    assign stall_d = accept_mul || (mul_busy && !mul_done);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept_mul) state_d = StMul;
            StMul:   if (mul_done) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q     <= 1'b0;
            hold_btgt_q <= '0;
            hold_wreg_q <= '0;
            hold_regw_q <= 1'b0;
        end else begin
            stall_q     <= stall_d;
            hold_btgt_q <= hold_btgt_d;
            hold_wreg_q <= hold_wreg_d;
            hold_regw_q <= hold_regw_d;
        end
    end

    assign stall = stall_q;
`else
    assign accept_mul = 1'b0;
    assign state_d    = StIdle;
    assign stall      = 1'b0;
`endif

    assign accept_alu = (state_q == StIdle) && validIn && !accept_mul;

    always_comb begin
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        btgt_d   = btgt_q;
        wreg_d   = wreg_q;
        regw_d   = 1'b0;
        valid_d  = 1'b0;
`ifdef EXEC_MUL_EN
        hold_btgt_d = hold_btgt_q;
        hold_wreg_d = hold_wreg_q;
        hold_regw_d = hold_regw_q;
        if (accept_mul) begin
            hold_btgt_d = btgt_new;
            hold_wreg_d = writeRegisterIn;
            hold_regw_d = regWriteIn;
        end
        if (state_q == StMul && mul_done) begin
            result_d = mul_product;
            zero_d   = (mul_product == '0);
            carry_d  = 1'b0;
            ovf_d    = 1'b0;
            btgt_d   = hold_btgt_q;
            wreg_d   = hold_wreg_q;
            regw_d   = hold_regw_q;
            valid_d  = 1'b1;
        end
`endif
        if (accept_alu) begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            carry_d  = alu_c;
            ovf_d    = alu_v;
            btgt_d   = btgt_new;
            wreg_d   = writeRegisterIn;
            regw_d   = regWriteIn && is_single_cycle_op(aluOp);
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            btgt_q   <= '0;
            wreg_q   <= '0;
            regw_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            btgt_q   <= btgt_d;
            wreg_q   <= wreg_d;
            regw_q   <= regw_d;
            valid_q  <= valid_d;
        end
    end

    assign validOut         = valid_q;
    assign aluResult        = result_q;
    assign zero             = zero_q;
    assign carry            = carry_q;
    assign overflow         = ovf_q;
    assign branchTarget     = btgt_q;
    assign writeRegisterOut = wreg_q;
    assign regWriteOut      = regw_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage; multiplier expectations follow EXEC_MUL_EN.
module tb_execute_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        validIn = 1'b0;
    logic [3:0]  aluOp = 4'b0000;
    logic        aluSRC = 1'b0;
    logic [31:0] readData1 = '0;
    logic [31:0] readData2 = '0;
    logic [31:0] pcOffsetFilled = '0;
    logic [31:0] pcIn = '0;
    logic [4:0]  writeRegisterIn = '0;
    logic        regWriteIn = 1'b0;
    logic        stall;
    logic        validOut;
    logic [31:0] aluResult;
    logic        zero;
    logic        carry;
    logic        overflow;
    logic [31:0] branchTarget;
    logic [4:0]  writeRegisterOut;
    logic        regWriteOut;

    int total = 0;
    int bad   = 0;
    int n;
    int stall_cnt;
    int pulses;

`ifdef EXEC_MUL_EN
    localparam int          MulLat   = 32;
    localparam logic        MulRegW  = 1'b1;
    localparam logic [31:0] Prod6x7  = 32'd42;
    localparam logic [31:0] ProdFx2  = 32'hFFFF_FFFE;
`else
    localparam int          MulLat   = 0;
    localparam logic        MulRegW  = 1'b0;
    localparam logic [31:0] Prod6x7  = 32'd0;
    localparam logic [31:0] ProdFx2  = 32'd0;
`endif

    execute_stage u_dut (
        .clock            (clock),
        .reset            (reset),
        .validIn          (validIn),
        .aluOp            (aluOp),
        .aluSRC           (aluSRC),
        .readData1        (readData1),
        .readData2        (readData2),
        .pcOffsetFilled   (pcOffsetFilled),
        .pcIn             (pcIn),
        .writeRegisterIn  (writeRegisterIn),
        .regWriteIn       (regWriteIn),
        .stall            (stall),
        .validOut         (validOut),
        .aluResult        (aluResult),
        .zero             (zero),
        .carry            (carry),
        .overflow         (overflow),
        .branchTarget     (branchTarget),
        .writeRegisterOut (writeRegisterOut),
        .regWriteOut      (regWriteOut)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic src, input logic [31:0] off, input logic [31:0] pc,
                        input logic [4:0] wr, input logic rw);
        @(negedge clock);
        aluOp           = op;
        readData1       = a;
        readData2       = b;
        aluSRC          = src;
        pcOffsetFilled  = off;
        pcIn            = pc;
        writeRegisterIn = wr;
        regWriteIn      = rw;
        validIn         = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clock);
        validIn = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_valid();
        n = 0;
        stall_cnt = int'(stall);
        while (!validOut && n < 40) begin
            @(posedge clock);
            #1;
            n++;
            if (stall) stall_cnt++;
        end
    endtask

    initial begin
        // Reset held with a valid ADD presented: nothing may leak through.
        readData1 = 32'd3; readData2 = 32'd4; aluOp = 4'b0010; validIn = 1'b1; regWriteIn = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_valid", {31'd0, validOut}, 32'd0);
        chk("rst_result", aluResult, 32'd0);
        chk("rst_flags", {29'd0, zero, carry, overflow}, 32'd0);
        chk("rst_btgt", branchTarget, 32'd0);
        chk("rst_wreg_regw", {26'd0, writeRegisterOut, regWriteOut}, 32'd0);
        @(negedge clock);
        validIn = 1'b0;
        reset   = 1'b0;

        send(4'b0010, 32'd5, 32'd7, 1'b0, 32'd2, 32'h10, 5'd3, 1'b1);
        chk("add_result", aluResult, 32'd12);
        chk("add_flags", {29'd0, zero, carry, overflow}, 32'd0);
        chk("add_valid", {31'd0, validOut}, 32'd1);
        chk("add_regw", {26'd0, writeRegisterOut, regWriteOut}, {26'd0, 5'd3, 1'b1});
        chk("add_btgt", branchTarget, 32'h18);
        idle_cycle();
        chk("idle_valid_regw", {30'd0, validOut, regWriteOut}, 32'd0);
        chk("idle_hold", aluResult, 32'd12);

        send(4'b0110, 32'd9, 32'd9, 1'b0, 32'd0, 32'd0, 5'd4, 1'b1);
        chk("sub_result", aluResult, 32'd0);
        chk("sub_flags", {29'd0, zero, carry, overflow}, 32'b110);

        send(4'b0010, 32'h7FFF_FFFF, 32'd0, 1'b1, 32'd1, 32'h100, 5'd1, 1'b1);
        chk("ovf_result", aluResult, 32'h8000_0000);
        chk("ovf_flags", {29'd0, zero, carry, overflow}, 32'b001);
        chk("ovf_btgt", branchTarget, 32'h104);

        send(4'b0111, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFC, 32'h100, 5'd2, 1'b1);
        chk("passb_result", aluResult, 32'hFFFF_FFFC);
        chk("neg_btgt", branchTarget, 32'hF0);

        send(4'b0000, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, 32'd0, 32'd0, 5'd2, 1'b1);
        chk("and_result", aluResult, 32'h0000_F000);
        send(4'b0001, 32'h0000_F0F0, 32'h0000_FF00, 1'b0, 32'd0, 32'd0, 5'd2, 1'b1);
        chk("orr_result", aluResult, 32'h0000_FFF0);
        send(4'b1100, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 5'd2, 1'b1);
        chk("nor_result", aluResult, 32'hFFFF_FFFF);
        chk("nor_zero", {31'd0, zero}, 32'd0);

        send(4'b0011, 32'd5, 32'd7, 1'b0, 32'd0, 32'd0, 5'd9, 1'b1);
        chk("undef_result", aluResult, 32'd0);
        chk("undef_valid_regw", {30'd0, validOut, regWriteOut}, 32'b10);
        chk("undef_zero", {31'd0, zero}, 32'd1);

        // MUL 6x7 with upstream going idle while stalled.
        send(4'b1000, 32'd6, 32'd7, 1'b0, 32'd1, 32'h200, 5'd5, 1'b1);
        validIn = 1'b0;
        wait_valid();
        chk("mul_latency", n, MulLat);
        chk("mul_stall_cycles", stall_cnt, MulLat);
        chk("mul_result", aluResult, Prod6x7);
        chk("mul_done_stall", {31'd0, stall}, 32'd0);
        chk("mul_regw", {26'd0, writeRegisterOut, regWriteOut}, {26'd0, 5'd5, MulRegW});
        chk("mul_btgt", branchTarget, 32'h204);

        // MUL then an ADD held on the inputs for the whole stall.
        send(4'b1000, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'd0, 32'd0, 5'd6, 1'b1);
        aluOp = 4'b0010; readData1 = 32'd3; readData2 = 32'd4; writeRegisterIn = 5'd7;
        wait_valid();
        chk("mul2_latency", n, MulLat);
        chk("mul2_result", aluResult, ProdFx2);
        @(posedge clock);
        #1;
        chk("b2b_valid", {31'd0, validOut}, 32'd1);
        chk("b2b_result", aluResult, 32'd7);
        chk("b2b_wreg", {27'd0, writeRegisterOut}, 32'd7);
        idle_cycle();

        // Reset lands mid-multiply; the aborted op must never produce a pulse.
        send(4'b1000, 32'd6, 32'd7, 1'b0, 32'd3, 32'h40, 5'd8, 1'b1);
        validIn = 1'b0;
        repeat (10) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_stall_valid", {30'd0, stall, validOut}, 32'd0);
        chk("abort_result", aluResult, 32'd0);
        chk("abort_btgt", branchTarget, 32'd0);
        chk("abort_rest", {24'd0, zero, carry, overflow, writeRegisterOut, regWriteOut}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (validOut || stall) pulses++;
        end
        chk("abort_no_pulse", pulses, 32'd0);
        send(4'b0010, 32'd1, 32'd1, 1'b0, 32'd0, 32'd0, 5'd1, 1'b1);
        chk("post_rst_add", aluResult, 32'd2);
        chk("post_rst_valid", {31'd0, validOut}, 32'd1);
        idle_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the ARM-LP pipeline, directly downstream of operand preparation. Consumes the two register operands, the sign-extended offset and the ALU-source select; produces a registered ALU result, condition flags and branch target. Single-cycle ALU ops complete in one clock. An optional iterative multiplier stalls upstream while it runs.

## Interface
- WIDTH, 32, datapath width
- MUL_STEPS, WIDTH, multiplier iterations (one operand bit per step)

Ports:
- clock  in  1  main clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- validIn  in  1  operands and op valid this cycle
- aluOp  in  4  0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 PASSB, 1100 NOR, 1000 MUL
- aluSRC  in  1  0: operand B = readData2; 1: operand B = pcOffsetFilled
- readData1  in  WIDTH  operand A
- readData2  in  WIDTH  register operand B
- pcOffsetFilled  in  WIDTH  sign-extended offset/immediate
- pcIn  in  WIDTH  PC of the instruction
- writeRegisterIn  in  5  destination, passed through
- regWriteIn  in  1  write enable, passed through
- stall  out  1  registered; high while multiplier busy, upstream must hold inputs
- validOut  out  1  result valid (one-cycle pulse per instruction)
- aluResult  out  WIDTH  registered result
- zero  out  1  aluResult == 0
- carry  out  1  carry-out of ADD/SUB, else 0
- overflow  out  1  signed overflow of ADD/SUB, else 0
- branchTarget  out  WIDTH  pcIn + (pcOffsetFilled << 2)
- writeRegisterOut  out  5  registered pass-through
- regWriteOut  out  1  registered pass-through, gated by validOut

## Operation
- Operand B = aluSRC ? pcOffsetFilled : readData2.
- SUB = A + ~B + 1; carry is the adder carry-out; overflow = sign(A)==sign(B') && sign(result)!=sign(A).
- All arithmetic wraps modulo 2^WIDTH; MUL returns low WIDTH bits of the unsigned product.
- branchTarget computed for every accepted instruction, wraps modulo 2^WIDTH.
- FSM states: IDLE, MUL.
  - IDLE, validIn=1, non-MUL op: register results, validOut=1, stay IDLE.
  - IDLE, validIn=1, MUL: latch A, B, pass-through fields; clear accumulator and step counter; go MUL; stall=1; validOut=0.
  - MUL: one shift-add step per clock; inputs ignored. After MUL_STEPS steps, write product to aluResult, validOut=1, go IDLE, stall=0.
  - IDLE, validIn=0: validOut=0, other outputs hold.
- Undefined aluOp codes: aluResult=0, validOut=1, regWriteOut=0.

## Timing
- Reset values: stall=0, validOut=0, aluResult=0, zero=0, carry=0, overflow=0, branchTarget=0, writeRegisterOut=0, regWriteOut=0, state IDLE, counter 0.
- Non-MUL latency: 1 clock (inputs sampled at edge E0, outputs valid after E0).
- MUL: accepted at E0, stall high after E0 through E(MUL_STEPS); result and validOut after E(MUL_STEPS); stall low in the same cycle; next instruction accepted at E(MUL_STEPS+1).
- Reset asserted mid-MUL: abort immediately, outputs to reset values, no validOut pulse for the aborted op.
- validIn while stall=1: ignored, not queued.

## Configuration
- EXEC_MUL_EN defined: multiplier and MUL state built as above.
- Not defined: no MUL state; MUL treated as undefined op (result 0, regWriteOut=0, 1-cycle); stall tied 0.

## Structure
- Shared package arm_lp_pkg: aluOp encodings, FSM state enum, WIDTH default.
- Sub-module mul_iter: shift-add multiplier with start/busy/done, instantiated only under EXEC_MUL_EN.

## Test plan
- ADD, A=5, B=7, aluSRC=0 -> aluResult=12, zero=0, carry=0, validOut 1 cycle after.
- SUB, A=9, B=9 -> aluResult=0, zero=1, carry=1, overflow=0.
- ADD, A=0x7FFFFFFF, pcOffsetFilled=1, aluSRC=1 -> aluResult=0x80000000, overflow=1; pcIn=0x100, offset=0xFFFFFFFC -> branchTarget=0xF0.
- MUL 6x7 -> stall high 32 cycles, aluResult=42, validOut at cycle 32; MUL 0xFFFFFFFF x 2 -> 0xFFFFFFFE.
- Back-to-back: MUL then ADD held by upstream during stall -> ADD result exactly 1 cycle after MUL result.
- Reset asserted at MUL step 10 -> all outputs 0 at once, no validOut; post-reset ADD 1+1 -> 2.
